// File: rtl/matrix_scan_driver.sv
// -----------------------------------------------------------------------------
// matrix_scan_driver
//
// Drives a 5-column x 7-row LED matrix by column-multiplexed scanning. A full
// snapshot of the selected map is captured into a frame buffer at every frame
// boundary, so the picture never tears when the source map or the map-select
// switch changes mid-scan. Every column is preceded by a blanking gap
// (all columns off) to suppress ghosting.
//
// Scan sequence per column: BLANK for BLANK_CYCLES clocks, then DRIVE for
// CLK_DIV clocks. Column order is a..e (0..4). Frame period is
// 5 * (CLK_DIV + BLANK_CYCLES) clocks.
//
// Parameters:
//   CLK_DIV      clocks each column is driven (>= 1)
//   BLANK_CYCLES clocks all columns are off between columns (>= 1)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   en          scan enable; low blanks the display and holds the scan at start
//   pix[34:0]   final map, bit index = row*5 + col
//   col_n[4:0]  active-low column select, at most one bit low
//   row[6:0]    active-high row data for the driven column
//   frame_start one-cycle pulse on the first DRIVE cycle of column 0
// -----------------------------------------------------------------------------
module matrix_scan_driver #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [34:0] pix,
    output logic [4:0]  col_n,
    output logic [6:0]  row,
    output logic        frame_start
);

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [2:0]       COL_LAST   = 3'd4;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       col_q, col_d;
    logic [34:0]      fb_q, fb_d;
    logic             frame_start_q, frame_start_d;
    logic [4:0]       col_n_q, col_n_d;
    logic [6:0]       row_q, row_d;
    logic [34:0]      fb_shift;

    // Next-state logic for the scan sequencer and frame buffer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; a missing default in always_comb infers a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        col_d         = col_q;
        fb_d          = fb_q;
        frame_start_d = 1'b0;

        if (!en) begin
            // Hold at the start of a frame; the frame buffer is kept.
            state_d = BLANK;
            cnt_d   = '0;
            col_d   = '0;
        end else begin
            unique case (state_q)
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = DRIVE;
                        cnt_d   = '0;
                        // Frame boundary: snapshot the map for the whole frame.
                        if (col_q == '0) begin
                            fb_d          = pix;
                            frame_start_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        col_d   = (col_q == COL_LAST) ? 3'd0 : col_q + 3'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state, registered alongside the state so
    // the pins reflect the current state with no added latency.
    assign fb_shift = fb_d >> col_d;

    always_comb begin
        col_n_d = 5'b11111;
        row_d   = 7'b0000000;
        if (state_d == DRIVE) begin
            col_n_d = ~(5'b00001 << col_d);
            for (int r = 0; r < 7; r++) begin
                row_d[r] = fb_shift[r*5];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            state_q       <= BLANK;
            cnt_q         <= '0;
            col_q         <= '0;
            // The frame buffer is reset too: after reset the display must not
            // show a stale map before the first capture.
            fb_q          <= '0;
            frame_start_q <= 1'b0;
            col_n_q       <= 5'b11111;
            row_q         <= 7'b0000000;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            col_q         <= col_d;
            fb_q          <= fb_d;
            frame_start_q <= frame_start_d;
            col_n_q       <= col_n_d;
            row_q         <= row_d;
        end
    end

    assign col_n       = col_n_q;
    assign row         = row_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_matrix_scan_driver
//
// Directed bench for matrix_scan_driver with CLK_DIV=4, BLANK_CYCLES=2
// (frame period 30 clocks). A frame position counter (0..29) gives the
// expected outputs: within each 6-clock column slot the first two clocks are
// blank and the next four drive that column; frame_start is expected at
// position 2. The expected frame buffer is the pix value present at the
// capture edge (the edge entering position 2).
// -----------------------------------------------------------------------------
module tb_matrix_scan_driver;

    localparam int CLK_DIV      = 4;
    localparam int BLANK_CYCLES = 2;
    localparam int SLOT         = CLK_DIV + BLANK_CYCLES;
    localparam int FRAME        = 5 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [34:0] pix;
    logic [4:0]  col_n;
    logic [6:0]  row;
    logic        frame_start;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          pos      = 0;
    logic [34:0] fb_exp   = '0;

    matrix_scan_driver #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pix         (pix),
        .col_n       (col_n),
        .row         (row),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [34:0] act, input logic [34:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        else
            n_pass++;
    endtask

    // Raw clock step: outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scan step while enabled and out of reset: advances the frame position
    // and records the captured map on the capture edge.
    task automatic step();
        logic [34:0] pix_at_edge;
        pix_at_edge = pix;
        tick();
        if (pos == BLANK_CYCLES - 1) fb_exp = pix_at_edge;
        pos = (pos + 1) % FRAME;
    endtask

    task automatic check_blank(input string tag);
        check({tag, " col_n"}, 35'(col_n), 35'h1f);
        check({tag, " row"}, 35'(row), 35'h0);
        check({tag, " fs"}, 35'(frame_start), 35'h0);
    endtask

    task automatic check_pos(input string tag);
        int         c;
        int         ph;
        logic [4:0] exp_col_n;
        logic [6:0] exp_row;
        logic       exp_fs;
        c  = pos / SLOT;
        ph = pos % SLOT;
        exp_col_n = 5'h1f;
        exp_row   = '0;
        exp_fs    = 1'b0;
        if (ph >= BLANK_CYCLES) begin
            exp_col_n    = 5'h1f;
            exp_col_n[c] = 1'b0;
            for (int r = 0; r < 7; r++) exp_row[r] = fb_exp[r*5 + c];
            exp_fs = (c == 0) && (ph == BLANK_CYCLES);
        end
        check($sformatf("%s p%0d col_n", tag, pos), 35'(col_n), 35'(exp_col_n));
        check($sformatf("%s p%0d row", tag, pos), 35'(row), 35'(exp_row));
        check($sformatf("%s p%0d fs", tag, pos), 35'(frame_start), 35'(exp_fs));
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check_pos(tag);
        end
    endtask

    task automatic run_to(input string tag, input int target);
        for (int i = 0; i < FRAME && pos != target; i++) begin
            step();
            check_pos(tag);
        end
        check($sformatf("%s reached p%0d", tag, target), 35'(pos), 35'(target));
    endtask

    initial begin
        // 1. Reset with pix all ones: outputs stay blank.
        rst_n = 1'b0;
        en    = 1'b1;
        pix   = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_blank($sformatf("reset c%0d", i));
        end

        // 2. First frame with only a0 lit: two blank cycles, then column a
        //    with row 0000001 for four cycles, frame_start on the first.
        pix    = 35'h1;
        rst_n  = 1'b1;
        pos    = 0;
        fb_exp = '0;
        check_pos("first");
        run("first", 1);
        run("first", 1);
        check("first col_a col_n", 35'(col_n), 35'h1e);
        check("first col_a row", 35'(row), 35'h01);
        check("first col_a fs", 35'(frame_start), 35'h1);
        run("first", FRAME - 3);

        // 3. Only e6 lit: column scan order a..e, row 1000000 only on e,
        //    frame_start every 30 cycles.
        pix = 35'h1 << 34;
        run("order", 2 * FRAME);
        run_to("order", 4 * SLOT + BLANK_CYCLES);
        check("order col_e col_n", 35'(col_n), 35'h0f);
        check("order col_e row", 35'(row), 35'h40);
        run_to("order", 0);

        // 4. Tear-free capture: switch to zeros while column c is driven;
        //    the rest of this frame keeps showing all ones.
        pix = '1;
        run_to("tear", 0);
        run_to("tear", 2 * SLOT + BLANK_CYCLES);
        check("tear col_c row", 35'(row), 35'h7f);
        pix = '0;
        run_to("tear", 4 * SLOT + BLANK_CYCLES + 1);
        check("tear col_e row", 35'(row), 35'h7f);
        run_to("tear", 0);
        run("tear", FRAME);

        // 5. Enable drop during column d drive: blank on the next cycle,
        //    then a full restart with a fresh capture on re-enable.
        pix = 35'h4_2108_4210;
        run_to("endrop", 3 * SLOT + BLANK_CYCLES + 1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_blank($sformatf("en_low c%0d", i));
        end
        pix = 35'h0_1234_5678;
        en  = 1'b1;
        pos = 0;
        check_pos("reen");
        run("reen", FRAME + 2);

        // 6. Reset mid-frame during column b with a captured all-ones buffer.
        pix = '1;
        run_to("rst_mid", 0);
        run_to("rst_mid", SLOT + BLANK_CYCLES + 1);
        check("rst_mid col_b row", 35'(row), 35'h7f);
        pix   = '0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_blank($sformatf("rst_mid c%0d", i));
        end
        rst_n  = 1'b1;
        pos    = 0;
        fb_exp = '0;
        check_pos("after_rst");
        run("after_rst", FRAME);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
